// File: rtl/timer_responder.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp behind a handshake
// responder with configurable wait states, and a registered interrupt output.
module timer_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_tip
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [15:0] pre_cnt;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic [31:0] wmask;
    logic [31:0] rd_sel;
    logic        tick;
    logic        go_ack;
    logic        do_wr;
    logic        unused_addr;

    assign unused_addr = ^{i_addr[31:4], i_addr[1:0]};

    always_comb begin
        tick   = (pre_cnt == PRE_MAX);
        go_ack = i_bus_en && (((state == IDLE) && (WAIT_STATES == 0)) ||
                              ((state == WAIT) && (wait_cnt == '0)));
        do_wr  = go_ack && i_wr_en;
        wmask  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{i_byte_en[i]}};
        end

        // Writes merge onto the already-incremented value so unwritten bytes keep counting
        mtime_inc    = mtime + 64'(tick);
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = mtimecmp;
        if (do_wr) begin
            case (i_addr[3:2])
                2'd0: mtime_nxt[31:0]     = (i_wr_data & wmask) | (mtime_inc[31:0]  & ~wmask);
                2'd1: mtime_nxt[63:32]    = (i_wr_data & wmask) | (mtime_inc[63:32] & ~wmask);
                2'd2: mtimecmp_nxt[31:0]  = (i_wr_data & wmask) | (mtimecmp[31:0]   & ~wmask);
                default: mtimecmp_nxt[63:32] = (i_wr_data & wmask) | (mtimecmp[63:32] & ~wmask);
            endcase
        end

        case (i_addr[3:2])
            2'd0:    rd_sel = mtime[31:0];
            2'd1:    rd_sel = mtime[63:32];
            2'd2:    rd_sel = mtimecmp[31:0];
            default: rd_sel = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            pre_cnt   <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            o_ack     <= 1'b0;
            o_rd_data <= '0;
            o_tip     <= 1'b0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + 16'd1;
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            o_tip    <= (mtime_nxt >= mtimecmp_nxt);
            o_ack    <= go_ack;
            if (go_ack && !i_wr_en) begin
                o_rd_data <= rd_sel;
            end

            case (state)
                IDLE: begin
                    if (i_bus_en) begin
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!i_bus_en) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
